// File: rtl/core_mem_arbiter.sv
// Purpose  : round-robin arbiter that merges an instruction fetch port and a data
//            port onto one memory request channel and routes responses back in
//            grant order. Grants are zero-latency; responses are routed in the
//            same cycle. An ungranted offer is held (locked) until it is granted.
//            Requests are held off while DEPTH transactions are outstanding.
// Ports    : clk/rst_n (async active-low); instr_* read-only request/response port;
//            data_* read/write request/response port; m_* shared request toward the
//            bridge and its response; proto_err_o sticky "response without owner".
module core_mem_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_req_i,
  input  logic [AW-1:0] instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [3:0]    m_be_o,
  output logic [AW-1:0] m_addr_o,
  output logic [31:0]   m_wdata_o,
  input  logic          m_gnt_i,
  input  logic          m_rvalid_i,
  input  logic [31:0]   m_rdata_i,
  input  logic          m_err_i,
  output logic          proto_err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

  logic             r_prio;       // ID favoured when both ports request
  logic             r_locked;     // an offer is pending without grant
  logic             r_lock_id;
  logic             r_proto_err;
  logic [DEPTH-1:0] r_owner;      // owner ID per outstanding slot
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_sel;
  logic w_req_raw;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_head  = r_owner[r_rd_ptr];

  // A locked offer only follows its own port's request; the other port is
  // ignored until the pending offer is granted or withdrawn.
  always_comb begin
    w_sel     = 1'b0;
    w_req_raw = 1'b0;
    if (r_locked) begin
      w_sel     = r_lock_id;
      w_req_raw = r_lock_id ? data_req_i : instr_req_i;
    end else begin
      w_req_raw = instr_req_i | data_req_i;
      if (instr_req_i & data_req_i) w_sel = r_prio;
      else                          w_sel = data_req_i;
    end
  end

  // rst_n gates the handshake outputs so they are quiet for the whole reset.
  assign w_req  = w_req_raw & ~w_full & rst_n;
  assign w_push = w_req & m_gnt_i;
  assign w_pop  = m_rvalid_i & ~w_empty & rst_n;

  assign m_req_o   = w_req;
  assign m_we_o    = w_sel ? data_we_i    : 1'b0;
  assign m_be_o    = w_sel ? data_be_i    : 4'hF;
  assign m_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
  assign m_wdata_o = w_sel ? data_wdata_i : 32'h0;

  assign instr_gnt_o    = w_push & ~w_sel;
  assign data_gnt_o     = w_push &  w_sel;
  assign instr_rvalid_o = w_pop  & ~w_head;
  assign data_rvalid_o  = w_pop  &  w_head;
  assign instr_rdata_o  = m_rdata_i;
  assign data_rdata_o   = m_rdata_i;
  assign instr_err_o    = m_err_i & instr_rvalid_o;
  assign data_err_o     = m_err_i & data_rvalid_o;
  assign proto_err_o    = r_proto_err;

  // Arbitration state: priority moves away from the winner on acceptance only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio    <= 1'b1;
      r_locked  <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      r_locked  <= w_req & ~m_gnt_i;
      r_lock_id <= w_sel;
      if (w_push) r_prio <= ~w_sel;
    end
  end

  // Owner FIFO. Pushes are already blocked at full, so a same-cycle pop and
  // push never collide on one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      if (w_push) begin
        r_owner[r_wr_ptr] <= w_sel;
        r_wr_ptr          <= f_next(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_rvalid_i & w_empty) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Purpose  : randomized scoreboard bench for core_mem_arbiter. The stimulus process
//            drives ports, evaluates a queue-based reference model and pushes
//            expected per-cycle, grant and response records; a monitor pops them.
// Ports    : none (top-level bench); clock period 10 time units.
module tb_core_mem_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int NCYC  = 460;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]   instr_rdata_o;
  logic          data_req_i = 1'b0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = 4'h0;
  logic [AW-1:0] data_addr_i = '0;
  logic [31:0]   data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]   data_rdata_o;
  logic          m_req_o, m_we_o;
  logic [3:0]    m_be_o;
  logic [AW-1:0] m_addr_o;
  logic [31:0]   m_wdata_o;
  logic          m_gnt_i = 1'b0;
  logic          m_rvalid_i = 1'b0;
  logic [31:0]   m_rdata_i = '0;
  logic          m_err_i = 1'b0;
  logic          proto_err_o;

  always #5 clk = ~clk;

  core_mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .proto_err_o(proto_err_o)
  );

  typedef struct {
    int          cyc;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        proto;
  } cyc_t;
  typedef struct { int cyc; logic id; } gnt_t;
  typedef struct { int cyc; logic id; logic err; logic [31:0] rdata; } rsp_t;

  cyc_t cyc_q[$];
  gnt_t gnt_q[$];
  rsp_t rsp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit done = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    cyc_t c;
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (cyc_q.size() == 0) flag("no_cycle_record");
        else begin
          c = cyc_q.pop_front();
          check("m_req", 64'(m_req_o), 64'(c.req));
          check("proto_err", 64'(proto_err_o), 64'(c.proto));
          if (c.req) begin
            check("m_addr", 64'(m_addr_o), 64'(c.addr));
            check("m_we", 64'(m_we_o), 64'(c.we));
            check("m_be", 64'(m_be_o), 64'(c.be));
            check("m_wdata", 64'(m_wdata_o), 64'(c.wdata));
          end
        end
        if (instr_gnt_o || data_gnt_o) begin
          if (instr_gnt_o && data_gnt_o) flag("double_grant");
          else if (gnt_q.size() == 0) flag("unexpected_grant");
          else begin
            g = gnt_q.pop_front();
            check("grant_id", 64'(data_gnt_o), 64'(g.id));
            check("grant_cycle", 64'(cyc), 64'(g.cyc));
          end
        end else if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
          void'(gnt_q.pop_front());
          flag("missing_grant");
        end
        if (instr_rvalid_o || data_rvalid_o) begin
          if (instr_rvalid_o && data_rvalid_o) flag("double_rvalid");
          else if (rsp_q.size() == 0) flag("unexpected_rvalid");
          else begin
            r = rsp_q.pop_front();
            check("rsp_id", 64'(data_rvalid_o), 64'(r.id));
            check("rsp_cycle", 64'(cyc), 64'(r.cyc));
            check("rsp_err", {62'd0, instr_err_o, data_err_o},
                  {62'd0, r.err & ~r.id, r.err & r.id});
            check("rsp_rdata", 64'(r.id ? data_rdata_o : instr_rdata_o), 64'(r.rdata));
          end
        end else begin
          if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
            void'(rsp_q.pop_front());
            flag("missing_rvalid");
          end
          if (instr_err_o || data_err_o) flag("err_without_rvalid");
        end
      end
    end
  end

  // Stimulus and reference model. The model keeps outstanding owners in a queue,
  // remembers who was last granted and whether an offer is pending ungranted.
  initial begin
    int   owners[$];
    bit   last_g, hold_v, hold_id, proto_m, acc_prev, sel_prev;
    bit   in_reset, full, mreq, sel, acc;
    int   id;
    cyc_t rec;
    last_g = 1'b0; hold_v = 1'b0; hold_id = 1'b0; proto_m = 1'b0;
    acc_prev = 1'b0; sel_prev = 1'b0;
    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      in_reset = (c <= 3) || (c == 200) || (c == 201);

      // Ports hold a request until granted, occasionally withdrawing it.
      if (instr_req_i) begin
        if (acc_prev && !sel_prev) begin
          if ($urandom_range(0, 1) == 1) instr_addr_i = $urandom;
          else instr_req_i = 1'b0;
        end else if ($urandom_range(0, 19) == 0) instr_req_i = 1'b0;
      end else if ($urandom_range(0, 9) < 6) begin
        instr_req_i = 1'b1;
        instr_addr_i = $urandom;
      end
      if (data_req_i) begin
        if (acc_prev && sel_prev) begin
          if ($urandom_range(0, 1) == 1) begin
            data_addr_i = $urandom; data_wdata_i = $urandom;
            data_we_i = 1'($urandom); data_be_i = 4'($urandom);
          end else data_req_i = 1'b0;
        end else if ($urandom_range(0, 19) == 0) data_req_i = 1'b0;
      end else if ($urandom_range(0, 9) < 6) begin
        data_req_i = 1'b1; data_addr_i = $urandom; data_wdata_i = $urandom;
        data_we_i = 1'($urandom); data_be_i = 4'($urandom);
      end
      if (c == 202) begin
        instr_req_i = 1'b1;
        data_req_i = 1'b1;
      end

      rst_n      = in_reset ? 1'b0 : 1'b1;
      m_gnt_i    = ($urandom_range(0, 99) < 60);
      m_err_i    = ($urandom_range(0, 99) < 30);
      m_rdata_i  = $urandom;
      if (in_reset || c > 400) m_rvalid_i = ($urandom_range(0, 99) < 40);
      else m_rvalid_i = (owners.size() > 0) && ($urandom_range(0, 1) == 1);

      if (in_reset) begin
        owners.delete();
        hold_v = 1'b0; last_g = 1'b0; proto_m = 1'b0; acc_prev = 1'b0;
        rec = '{c, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0};
        cyc_q.push_back(rec);
      end else begin
        full = (owners.size() == DEPTH);
        if (hold_v) begin
          sel  = hold_id;
          mreq = (hold_id ? data_req_i : instr_req_i) && !full;
        end else begin
          mreq = (instr_req_i || data_req_i) && !full;
          sel  = (instr_req_i && data_req_i) ? !last_g : data_req_i;
        end
        rec = '{c, mreq, sel ? data_addr_i : instr_addr_i, sel ? data_we_i : 1'b0,
                sel ? data_be_i : 4'hF, sel ? data_wdata_i : 32'h0, proto_m};
        cyc_q.push_back(rec);
        acc = mreq && m_gnt_i;
        if (acc) gnt_q.push_back('{c, sel});
        if (m_rvalid_i) begin
          if (owners.size() > 0) begin
            id = owners.pop_front();
            rsp_q.push_back('{c, id[0], m_err_i, m_rdata_i});
          end else proto_m = 1'b1;
        end
        if (acc) begin
          owners.push_back(int'(sel));
          last_g = sel;
        end
        hold_v   = mreq && !m_gnt_i;
        hold_id  = sel;
        acc_prev = acc;
        sel_prev = sel;
      end
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    check("grants_left", 64'(gnt_q.size()), 64'd0);
    check("responses_left", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, maximum outstanding granted-but-unanswered transactions (>=1).
REQ-002 Parameter AW, default 32, address width; data width fixed at 32, byte-enable width 4.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_req_i  in  1  instruction port request; instr_addr_i  in  AW  instruction address (read-only port).
REQ-006 instr_gnt_o  out  1  request accepted; instr_rvalid_o  out  1  response; instr_rdata_o  out  32; instr_err_o  out  1.
REQ-007 data_req_i  in  1; data_we_i  in  1; data_be_i  in  4; data_addr_i  in  AW; data_wdata_i  in  32  data port request fields.
REQ-008 data_gnt_o  out  1; data_rvalid_o  out  1; data_rdata_o  out  32; data_err_o  out  1  data port response.
REQ-009 m_req_o  out  1; m_we_o  out  1; m_be_o  out  4; m_addr_o  out  AW; m_wdata_o  out  32  shared request toward the AXI4-Lite bridge.
REQ-010 m_gnt_i  in  1; m_rvalid_i  in  1; m_rdata_i  in  32; m_err_i  in  1  shared response from the bridge.
REQ-011 proto_err_o  out  1  sticky flag: response with no outstanding owner.

Function
REQ-012 Arbitration SHALL be round-robin between instr (ID 0) and data (ID 1); a single requester SHALL be selected whenever it alone requests.
REQ-013 Priority pointer SHALL update only on an accepted transfer (m_req_o & m_gnt_i), to favour the non-granted ID next.
REQ-014 Instr port forwarded as m_we_o=0, m_be_o=4'hF, m_wdata_o=0; data port fields forwarded unchanged.
REQ-015 m_req_o SHALL be (instr_req_i | data_req_i) & ~full, combinational from current inputs and state.
REQ-016 Lock: when m_req_o=1 and m_gnt_i=0, the selected ID SHALL be registered and held until the cycle m_gnt_i=1; no switching while locked, even if the other port requests.
REQ-017 While locked, m_req_o SHALL stay high and m_* SHALL show the locked port's fields; if the locked port drops its request, m_req_o follows it low and the lock clears.
REQ-018 instr_gnt_o = m_gnt_i & m_req_o & (sel==0); data_gnt_o = m_gnt_i & m_req_o & (sel==1); zero cycle latency.
REQ-019 Owner FIFO, DEPTH entries, 1-bit ID: push selected ID on accepted transfer; pop on m_rvalid_i when non-empty.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; pop precedes push when full (push still blocked by REQ-015 when full at cycle start).
REQ-021 full = (count==DEPTH); at full no grant SHALL be forwarded and m_req_o=0.
REQ-022 Response routing: x_rvalid_o = m_rvalid_i & non-empty & (head ID==x), same cycle; rdata_o of both ports = m_rdata_i; x_err_o = m_err_i & x_rvalid_o.
REQ-023 m_rvalid_i with empty FIFO SHALL be dropped (no rvalid to either port) and set proto_err_o until reset.
REQ-024 Responses SHALL return to ports in grant order; count width ceil(log2(DEPTH+1)).

Reset
REQ-025 On rst_n low: FIFO empty, count=0, lock cleared, priority pointer favours data (ID 1), proto_err_o=0.
REQ-026 During reset all gnt/rvalid/err outputs SHALL be 0 and m_req_o=0 regardless of inputs; outstanding transactions at reset assertion are discarded.

Verification
REQ-027 Both ports request, m_gnt_i=1 every cycle, responses 1 cycle later -> grants alternate data, instr, data, instr; rvalids routed in same order.
REQ-028 instr_req_i=1 addr 0x100, m_gnt_i=0 for 3 cycles, data_req_i rises cycle 1 -> m_addr_o stays 0x100 all 4 cycles, instr_gnt_o in cycle 4, then data selected.
REQ-029 DEPTH=2, two grants, no response -> m_req_o=0 third cycle; m_rvalid_i with m_err_i=1 -> head owner gets rvalid+err, m_req_o reasserts next cycle.
REQ-030 Grant and response same cycle at count=1 -> count remains 1, correct head popped, new ID queued.
REQ-031 m_rvalid_i=1 with FIFO empty -> no port rvalid, proto_err_o=1 and stays 1 until rst_n low.
REQ-032 Assert rst_n low with 2 outstanding -> all outputs 0 immediately; after release first contested grant goes to data.
